// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler that shares one UART transmitter between NUM_REQ byte producers.
// Launches one byte at a time, waits for tx_done (or a timeout), then holds off GAP_CYCLES.
//
// state     | meaning
// ----------|---------------------------------------------------------------
// IDLE      | tracks cfg_baud; arbitrates pending requests round-robin
// SEND      | issues the one-cycle send_en for the accepted byte
// WAIT_DONE | waits for tx_done; aborts with timeout_err after TIMEOUT_CYCLES
// GAP       | idle spacing between frames before the next arbitration
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 2000000,
  localparam int ID_W          = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ*8-1:0] req_data,
  output logic [NUM_REQ-1:0]   ack,
  input  logic [2:0]           cfg_baud,
  output logic [2:0]           baud_set,
  output logic [7:0]           data_byte,
  output logic                 send_en,
  input  logic                 tx_done,
  input  logic                 uart_state,
  output logic                 busy,
  output logic [ID_W-1:0]      cur_id,
  output logic                 timeout_err
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_DONE = 2'd2,
    GAP       = 2'd3
  } state_t;

  // A zero-length gap still spends one cycle in GAP.
  localparam logic [31:0] GAP_LAST = (GAP_CYCLES == 0) ? 32'd0 : 32'(GAP_CYCLES - 1);
  localparam logic [31:0] TO_LAST  = 32'(TIMEOUT_CYCLES - 1);

  state_t          state;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] winner;
  logic [ID_W-1:0] cand;
  logic            win_vld;
  logic [31:0]     gap_cnt;
  logic [31:0]     to_cnt;

  // The transmitter busy level is informational; the timeout is a pure cycle count.
  logic unused_uart_state;
  assign unused_uart_state = uart_state;

  // Scan from farthest to nearest so the nearest requester after rr_ptr wins.
  always_comb begin
    winner  = '0;
    win_vld = 1'b0;
    cand    = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      cand = rr_ptr + ID_W'(i);
      if (req[cand]) begin
        winner  = cand;
        win_vld = 1'b1;
      end
    end
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ack         <= '0;
      send_en     <= 1'b0;
      timeout_err <= 1'b0;
      data_byte   <= 8'h00;
      cur_id      <= '0;
      baud_set    <= 3'd0;
      rr_ptr      <= ID_W'(NUM_REQ - 1);
      gap_cnt     <= '0;
      to_cnt      <= '0;
    end else begin
      ack         <= '0;
      send_en     <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          baud_set <= cfg_baud;
          if (win_vld) begin
            ack[winner] <= 1'b1;
            data_byte   <= req_data[{winner, 3'b000} +: 8];
            cur_id      <= winner;
            rr_ptr      <= winner;
            state       <= SEND;
          end
        end
        SEND: begin
          send_en <= 1'b1;
          to_cnt  <= '0;
          state   <= WAIT_DONE;
        end
        WAIT_DONE: begin
          // A completion in the last allowed cycle beats the timeout.
          if (tx_done) begin
            gap_cnt <= '0;
            state   <= GAP;
          end else if (to_cnt == TO_LAST) begin
            timeout_err <= 1'b1;
            gap_cnt     <= '0;
            state       <= GAP;
          end else begin
            to_cnt <= to_cnt + 32'd1;
          end
        end
        GAP: begin
          if (gap_cnt >= GAP_LAST) state <= IDLE;
          else gap_cnt <= gap_cnt + 32'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
